reg_file_sb: RTL

//  Parametrised multi-port integer register file with per-register scoreboard (pending bits).

---
 rtl/reg_file_pkg.sv | 11 +
 rtl/reg_file_sb_if.sv | 40 ++++
 rtl/reg_file_scoreboard.sv | 39 +++
 rtl/reg_file_sb.sv | 94 +++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants and basic types for the integer register file with scoreboard.
package reg_file_pkg;

    localparam int N_REGS = 32;
    localparam int XLEN   = 32;
    localparam int REG_AW = $clog2(N_REGS);

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   reg_data_t;

endpackage

// File: rtl/reg_file_sb_if.sv
// Issue/writeback/read bundle of the register file. The master side is issue logic,
// and the slave side is the register file itself.
interface reg_file_sb_if
    import reg_file_pkg::*;
#(
    parameter int n_regs_p   = N_REGS,
    parameter int wd_regs_p  = XLEN,
    parameter int n_rd_ports = 2,
    parameter int n_wr_ports = 1
) ();
    localparam int wd_addr_p = $clog2(n_regs_p);

    // There is no valid/ready handshake. Each enable is a one-cycle command that is
    // sampled on the rising clock edge. Read results appear one edge later and are
    // held while the read enable is low.
    logic [n_rd_ports-1:0]                 i_rd_en;
    logic [n_rd_ports-1:0][wd_addr_p-1:0]  i_rd_addr;
    logic [n_rd_ports-1:0][wd_regs_p-1:0]  o_rd_data;
    logic [n_rd_ports-1:0]                 o_rd_busy;
    logic                                  i_rsv_en;
    logic [wd_addr_p-1:0]                  i_rsv_addr;
    logic                                  i_flush;
    logic [n_wr_ports-1:0]                 i_wr_en;
    logic [n_wr_ports-1:0][wd_addr_p-1:0]  i_wr_addr;
    logic [n_wr_ports-1:0][wd_regs_p-1:0]  i_wr_data;
    logic [n_regs_p-1:0]                   o_pending;

    modport master (
        output i_rd_en, i_rd_addr, i_rsv_en, i_rsv_addr, i_flush,
               i_wr_en, i_wr_addr, i_wr_data,
        input  o_rd_data, o_rd_busy, o_pending
    );

    modport slave (
        input  i_rd_en, i_rd_addr, i_rsv_en, i_rsv_addr, i_flush,
               i_wr_en, i_wr_addr, i_wr_data,
        output o_rd_data, o_rd_busy, o_pending
    );

endinterface

// File: rtl/reg_file_scoreboard.sv
// Pending-bit vector: each bit marks a register that is waiting on an in-flight producer.
// Priority per register: flush, then reserve, then writeback, then hold. Bit 0 is never set.
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int n_regs_p   = N_REGS,
    parameter int n_wr_ports = 1,
    localparam int wd_addr_p = $clog2(n_regs_p)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 rsv_en,
    input  logic [wd_addr_p-1:0]                 rsv_addr,
    input  logic                                 flush,
    input  logic [n_wr_ports-1:0]                wr_en,
    input  logic [n_wr_ports-1:0][wd_addr_p-1:0] wr_addr,
    output logic [n_regs_p-1:0]                  pend_q,
    output logic [n_regs_p-1:0]                  pend_d
);

    always_comb begin
        pend_d = pend_q;
        for (int r = 1; r < n_regs_p; r++) begin
            for (int j = 0; j < n_wr_ports; j++) begin
                if (wr_en[j] && (wr_addr[j] == wd_addr_p'(r))) pend_d[r] = 1'b0;
            end
            // A reservation in the same cycle as a writeback belongs to a newer producer, so it wins.
            if (rsv_en && (rsv_addr == wd_addr_p'(r))) pend_d[r] = 1'b1;
            if (flush) pend_d[r] = 1'b0;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) pend_q <= '0;
        else     pend_q <= pend_d;
    end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with registered reads and a pending-bit scoreboard.
// Define ARRISKV_RF_BYPASS_EN to make reads see same-cycle writes and next-state pending.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int n_regs_p   = N_REGS,
    parameter int wd_regs_p  = XLEN,
    parameter int n_rd_ports = 2,
    parameter int n_wr_ports = 1
) (
    input  logic          clk,
    input  logic          rst,
    reg_file_sb_if.slave  bus
);
    localparam int wd_addr_p = $clog2(n_regs_p);

    logic [wd_regs_p-1:0]                 regs [n_regs_p];
    logic [n_regs_p-1:0]                  pend_cur;
    logic [n_regs_p-1:0]                  pend_nxt;
    logic [wd_regs_p-1:0]                 rd_val [n_rd_ports];
    logic [n_rd_ports-1:0]                rd_bsy;
    logic [n_rd_ports-1:0][wd_regs_p-1:0] rd_data_q;
    logic [n_rd_ports-1:0]                rd_busy_q;

    reg_file_scoreboard #(
        .n_regs_p   (n_regs_p),
        .n_wr_ports (n_wr_ports)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .rsv_en   (bus.i_rsv_en),
        .rsv_addr (bus.i_rsv_addr),
        .flush    (bus.i_flush),
        .wr_en    (bus.i_wr_en),
        .wr_addr  (bus.i_wr_addr),
        .pend_q   (pend_cur),
        .pend_d   (pend_nxt)
    );

    // Ports are visited in ascending order, so the last (highest) port's write lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < n_regs_p; r++) regs[r] <= '0;
        end else begin
            for (int j = 0; j < n_wr_ports; j++) begin
                if (bus.i_wr_en[j] && (bus.i_wr_addr[j] != '0))
                    regs[bus.i_wr_addr[j]] <= bus.i_wr_data[j];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < n_rd_ports; i++) begin
            rd_val[i] = regs[bus.i_rd_addr[i]];
`ifdef ARRISKV_RF_BYPASS_EN
            rd_bsy[i] = pend_nxt[bus.i_rd_addr[i]];
            for (int j = 0; j < n_wr_ports; j++) begin
                if (bus.i_wr_en[j] && (bus.i_wr_addr[j] == bus.i_rd_addr[i]))
                    rd_val[i] = bus.i_wr_data[j];
            end
`else
            rd_bsy[i] = pend_cur[bus.i_rd_addr[i]];
`endif
            if (bus.i_rd_addr[i] == '0) begin
                rd_val[i] = '0;
                rd_bsy[i] = 1'b0;
            end
        end
    end

`ifndef ARRISKV_RF_BYPASS_EN
    logic unused_pend_nxt;
    assign unused_pend_nxt = ^pend_nxt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
            rd_busy_q <= '0;
        end else begin
            for (int i = 0; i < n_rd_ports; i++) begin
                if (bus.i_rd_en[i]) begin
                    rd_data_q[i] <= rd_val[i];
                    rd_busy_q[i] <= rd_bsy[i];
                end
            end
        end
    end

    assign bus.o_rd_data = rd_data_q;
    assign bus.o_rd_busy = rd_busy_q;
    assign bus.o_pending = pend_cur;

endmodule
